dlx_bus_slave: RTL

DLX_BUS_SLAVE -- requirements
Module: dlx_bus_slave

---
 rtl/dlx_bus_pkg.sv | 14 +
 rtl/dlx_slave_ram.sv | 35 +++
 rtl/dlx_bus_slave.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dlx_bus_pkg.sv
// Shared types and constants for the DLX bus slave and its storage.
package dlx_bus_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ACK   = 2'd2,
        ABORT = 2'd3
    } state_t;

endpackage

// File: rtl/dlx_slave_ram.sv
// Single-port word memory: synchronous write and registered read. The read register
// doubles as the slave's DO output, so it is the only state here that resets.
module dlx_slave_ram
    import dlx_bus_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array has no reset so it maps onto RAM macros and keeps its
    // contents across a reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dlx_bus_slave.sv
// Wait-stated DLX bus slave: IDLE/WAIT/ACK/ABORT handshake in front of a word memory.
// Optional write protection of the low PROT_WORDS words via `define DLX_SLV_WR_PROT_EN.
module dlx_bus_slave
    import dlx_bus_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2,
    parameter int PROT_WORDS  = 16
) (
    input  logic              CLK_IN,
    input  logic              RESET_N,
    input  logic              AS_N,
    input  logic              WR_N,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       DI,
    output logic [31:0]       DO,
    output logic              ACK_N,
    output logic              ERR_N,
    output logic              BUSY
);

    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    is_wr_q;
    logic [DATA_W-1:0]       di_q;
    logic                    latch;
    logic                    commit;
    logic                    prot_hit;
    logic                    ram_we;
    logic                    ram_re;

    // Byte lanes and high address bits alias onto the same word.
    logic unused_addr;
    assign unused_addr = ^{ADDR[31:DEPTH_LOG2+2], ADDR[1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            is_wr_q <= 1'b0;
            di_q    <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (latch) begin
                idx_q   <= ADDR[DEPTH_LOG2+1:2];
                is_wr_q <= ~WR_N;
                di_q    <= DI;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        latch   = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (!AS_N) begin
                    state_d = WAIT;
                    cnt_d   = WS_INIT;
                    latch   = 1'b1;
                end
            end
            WAIT: begin
                if (AS_N) begin
                    state_d = ABORT;
                end else if (cnt == '0) begin
                    state_d = ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ACK: begin
                if (AS_N) begin
                    state_d = IDLE;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef DLX_SLV_WR_PROT_EN
    assign prot_hit = $unsigned(32'(idx_q)) < $unsigned(32'(PROT_WORDS));
    assign ERR_N    = ~((state == ACK) & is_wr_q & prot_hit);
`else
    logic unused_prot;
    assign unused_prot = $unsigned(32'(idx_q)) < $unsigned(32'(PROT_WORDS));
    assign prot_hit    = 1'b0;
    assign ERR_N       = 1'b1;
`endif

    // Memory is touched only on the WAIT-to-ACK edge, so aborts and resets never commit.
    assign ram_we = commit & is_wr_q & ~prot_hit;
    assign ram_re = commit & ~is_wr_q;

    assign ACK_N = (state != ACK);
    assign BUSY  = (state != IDLE);

    dlx_slave_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (CLK_IN),
        .rst_n (RESET_N),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (idx_q),
        .wdata (di_q),
        .rdata (DO)
    );

endmodule
